prog_loader: RTL and testbench

//  Byte-stream program loader; the initiator for the CPU top's external memory-load port.
//  - Accepts a framed byte stream over a valid/ready interface.
//  - Assembles little-endian 32-bit words and drives Ext_MemWrite/Ext_DataAdr/Ext_WriteData.
//  - Holds cpu_reset high while loading, because that port is only honoured during reset.
//  - Releases cpu_reset when the load completes; sits between the host link (UART RX) and the CPU top.

---
 rtl/prog_loader.sv | 178 +++++++++++++++++
 tb/tb_prog_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader. Receives a framed stream (16-bit word count,
// then little-endian 32-bit words), writes each word into the CPU top's
// external memory-load port, and holds the CPU in reset until the load ends.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        Ext_MemWrite,
    output logic [31:0] Ext_DataAdr,
    output logic [31:0] Ext_WriteData,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_len;
    logic [15:0] r_idx;
    logic [1:0]  r_bcnt;
    logic [23:0] r_shift;
    logic [31:0] r_adr;
    logic [31:0] r_wdata;
    logic        r_rx_ready;
    logic        r_mem_write;
    logic        r_cpu_reset;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_accept;
    logic [15:0] w_len_full;
    logic [15:0] w_idx_inc;
    logic [31:0] w_word;

    // A byte moves only when the registered ready meets valid.
    assign w_accept   = rx_valid & r_rx_ready;
    assign w_len_full = {rx_data, r_len[7:0]};
    assign w_idx_inc  = r_idx + 16'd1;
    assign w_word     = {rx_data, r_shift};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is only honoured outside the busy states.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LEN0;
                else       w_next = S_IDLE;
            end
            S_LEN0: begin
                if (w_accept) w_next = S_LEN1;
                else          w_next = S_LEN0;
            end
            S_LEN1: begin
                if (!w_accept)                w_next = S_LEN1;
                else if (w_len_full == 16'd0) w_next = S_DONE;
                else if (w_len_full > MAX_N)  w_next = S_ERROR;
                else                          w_next = S_DATA;
            end
            S_DATA: begin
                if (w_accept && (r_bcnt == 2'd3)) w_next = S_WRITE;
                else                              w_next = S_DATA;
            end
            S_WRITE: begin
                if (w_idx_inc == r_len) w_next = S_DONE;
                else                    w_next = S_DATA;
            end
            S_DONE, S_ERROR: begin
                if (start) w_next = S_LEN0;
                else       w_next = r_state;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Length capture, word assembly, write address/data and word index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len   <= 16'd0;
            r_idx   <= 16'd0;
            r_bcnt  <= 2'd0;
            r_shift <= 24'd0;
            r_adr   <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_idx  <= 16'd0;
                        r_bcnt <= 2'd0;
                    end
                end
                S_LEN0: begin
                    if (w_accept) r_len[7:0] <= rx_data;
                end
                S_LEN1: begin
                    if (w_accept) r_len[15:8] <= rx_data;
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_bcnt  <= r_bcnt + 2'd1;
                        r_shift <= {rx_data, r_shift[23:8]};
                        if (r_bcnt == 2'd3) begin
                            // Address wraps modulo 2^32 by construction.
                            r_adr   <= BASE_ADDR + {14'd0, r_idx, 2'b00};
                            r_wdata <= w_word;
                        end
                    end
                end
                S_WRITE: begin
                    r_idx <= w_idx_inc;
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_ready  <= 1'b0;
            r_mem_write <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rx_ready  <= (w_next == S_LEN0) || (w_next == S_LEN1) || (w_next == S_DATA);
            r_mem_write <= (w_next == S_WRITE);
            r_cpu_reset <= (w_next != S_DONE);
            r_busy      <= (w_next == S_LEN0) || (w_next == S_LEN1) ||
                           (w_next == S_DATA) || (w_next == S_WRITE);
            r_done      <= (w_next == S_DONE);
            r_err       <= (w_next == S_ERROR);
        end
    end

    assign rx_ready      = r_rx_ready;
    assign Ext_MemWrite  = r_mem_write;
    assign Ext_DataAdr   = r_adr;
    assign Ext_WriteData = r_wdata;
    assign cpu_reset     = r_cpu_reset;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 0 and base 0xFFFF_FFFC) share
// one randomized byte stream; expected writes are queued by the driver and
// checked by per-instance monitors.
module tb_prog_loader;

    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'hFFFF_FFFC;
    localparam int          MAXW  = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        rdy0, mw0, cr0, busy0, done0, err0;
    logic [31:0] adr0, dat0;
    logic        rdy1, mw1, cr1, busy1, done1, err1;
    logic [31:0] adr1, dat1;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        time         t;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0, e1;
    logic [31:0] words[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    time         last_acc;
    time         word_end;

    always #5 clk = ~clk;

    prog_loader #(.BASE_ADDR(BASE0), .MAX_WORDS(MAXW)) u_dut0 (
        .clk(clk), .reset(reset_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rdy0), .Ext_MemWrite(mw0), .Ext_DataAdr(adr0), .Ext_WriteData(dat0),
        .cpu_reset(cr0), .busy(busy0), .done(done0), .err(err0)
    );

    prog_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(MAXW)) u_dut1 (
        .clk(clk), .reset(reset_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rdy1), .Ext_MemWrite(mw1), .Ext_DataAdr(adr1), .Ext_WriteData(dat1),
        .cpu_reset(cr1), .busy(busy1), .done(done1), .err(err1)
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Monitor for instance 0.
    always @(negedge clk) begin
        if (reset_n && mw0) begin
            if (q0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write0: got adr %h dat %h, expected no write", adr0, dat0);
            end else begin
                e0 = q0.pop_front();
                chk32("wr_adr0", adr0, e0.adr);
                chk32("wr_dat0", dat0, e0.dat);
                chk1("wr_cpu_reset0", cr0, 1'b1);
                chk32("wr_latency0", 32'($time - e0.t), 32'd5);
            end
        end
    end

    // Monitor for instance 1.
    always @(negedge clk) begin
        if (reset_n && mw1) begin
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write1: got adr %h dat %h, expected no write", adr1, dat1);
            end else begin
                e1 = q1.pop_front();
                chk32("wr_adr1", adr1, e1.adr);
                chk32("wr_dat1", dat1, e1.dat);
                chk1("wr_cpu_reset1", cr1, 1'b1);
                chk32("wr_latency1", 32'($time - e1.t), 32'd5);
            end
        end
    end

    // All tasks start and end at posedge+1.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        bit acc;
        int gap;
        gap = $urandom_range(0, gapmax);
        rx_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = rdy0;
            @(posedge clk);
        end
        if (acc) begin
            last_acc = $time;
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL byte_accept_timeout: got no rx_ready, expected byte %h accepted", b);
        end
        #1 rx_valid = 1'b0;
    endtask

    // Sends header n followed by every entry of words; queues one expected
    // write per completed word at BASE + 4*index.
    task automatic run_frame(input int n, input int gapmax, input bit busy_start);
        logic [31:0] w;
        send_byte(n[7:0], gapmax);
        send_byte(n[15:8], gapmax);
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            for (int j = 0; j < 4; j++) begin
                if (busy_start && ($urandom_range(0, 5) == 0)) pulse_start();
                send_byte(w[8*j +: 8], gapmax);
                if (i > 0 && j == 0)
                    chk1("byte_after_write_spacing", (last_acc - word_end) >= 20, 1'b1);
            end
            word_end = last_acc;
            q0.push_back('{adr: BASE0 + 32'(4 * i), dat: w, t: last_acc});
            q1.push_back('{adr: BASE1 + 32'(4 * i), dat: w, t: last_acc});
        end
    endtask

    task automatic check_status(input string name, input logic exp_done, input logic exp_err);
        for (int k = 0; k < 100 && (busy0 || busy1); k++) @(negedge clk);
        @(negedge clk);
        chk1({name, "_busy"}, busy0 | busy1, 1'b0);
        chk1({name, "_done0"}, done0, exp_done);
        chk1({name, "_err0"}, err0, exp_err);
        chk1({name, "_cpu_reset0"}, cr0, ~exp_done);
        chk1({name, "_rx_ready0"}, rdy0, 1'b0);
        chk1({name, "_done1"}, done1, exp_done);
        chk1({name, "_err1"}, err1, exp_err);
        chk1({name, "_cpu_reset1"}, cr1, ~exp_done);
        chk32({name, "_pending_writes"}, 32'(q0.size() + q1.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic random_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_cpu_reset", cr0 & cr1, 1'b1);
        chk1("rst_mem_write", mw0 | mw1, 1'b0);
        chk1("rst_rx_ready", rdy0 | rdy1, 1'b0);
        chk1("rst_busy", busy0 | busy1, 1'b0);
        chk1("rst_done_err", done0 | err0 | done1 | err1, 1'b0);
        chk32("rst_adr", adr0 | adr1, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk1("idle_cpu_reset", cr0, 1'b1);

        // Basic load.
        pulse_start();
        chk1("start_busy", busy0, 1'b1);
        chk1("start_rx_ready", rdy0, 1'b1);
        words.delete();
        words.push_back(32'h0050_0013);
        words.push_back(32'h00A0_0093);
        run_frame(2, 0, 1'b0);
        check_status("basic", 1'b1, 1'b0);

        // Restart from DONE, then a zero-length frame.
        pulse_start();
        chk1("restart_cpu_reset", cr0, 1'b1);
        chk1("restart_done_cleared", done0, 1'b0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk1("len0_done_next_edge", done0 & done1, 1'b1);
        chk1("len0_cpu_running", cr0, 1'b0);
        check_status("len0", 1'b1, 1'b0);

        // Oversize count is rejected.
        pulse_start();
        send_byte(8'h41, 0);
        send_byte(8'h00, 0);
        chk1("len65_err_next_edge", err0 & err1, 1'b1);
        chk1("len65_cpu_reset", cr0, 1'b1);
        check_status("len65", 1'b0, 1'b1);

        // Recovery from ERROR with a valid frame.
        pulse_start();
        chk1("err_cleared_on_start", err0, 1'b0);
        random_words(1);
        run_frame(1, 1, 1'b0);
        check_status("after_err", 1'b1, 1'b0);

        // Basic words under back-pressure with ignored starts.
        pulse_start();
        words.delete();
        words.push_back(32'h0050_0013);
        words.push_back(32'h00A0_0093);
        run_frame(2, 4, 1'b1);
        check_status("backpressure", 1'b1, 1'b0);

        // Randomized frames.
        for (int r = 0; r < 6; r++) begin
            pulse_start();
            random_words($urandom_range(1, 5));
            run_frame(words.size(), 3, 1'b1);
            check_status("random", 1'b1, 1'b0);
        end

        // Largest accepted count.
        pulse_start();
        random_words(MAXW);
        run_frame(MAXW, 0, 1'b0);
        check_status("max_words", 1'b1, 1'b0);

        // Reset mid-load after 6 bytes plus one partial byte.
        pulse_start();
        random_words(1);
        run_frame(3, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        send_byte(8'hAA, 0);
        #1 reset_n = 1'b0;
        #1;
        chk1("midrst_cpu_reset", cr0 & cr1, 1'b1);
        chk1("midrst_mem_write", mw0 | mw1, 1'b0);
        chk1("midrst_rx_ready", rdy0 | rdy1, 1'b0);
        chk1("midrst_busy", busy0 | busy1, 1'b0);
        chk32("midrst_pending", 32'(q0.size() + q1.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        pulse_start();
        random_words(2);
        run_frame(2, 1, 1'b0);
        check_status("after_midrst", 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
